spi_cs_ctrl: RTL and testbench
==============================

// Module: spi_cs_ctrl
// PURPOSE
//  Multi-channel SPI chip-select controller; successor to the single-CS select logic.
//  Drives NUM_CS select lines in auto mode (FSM-sequenced, with lead/trail/gap timing)
//  or manual mode (software mask). Sits between the SPI control register and the TX/RX shift FSM.
// PARAMETERS
//  NUM_CS   4  number of chip-select outputs (1..16)
//  SEL_W    2  width of cs_sel index; must satisfy 2**SEL_W >= NUM_CS
//  DELAY_W  4  width of the lead/trail/gap cycle counters
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  enable       in   1        block enable (control reg bit 15); 0 forces all CS inactive
//  cs_auto      in   1        1 = auto (FSM sequenced), 0 = manual
//  cs_manual    in   NUM_CS   manual assert mask, 1 = asserted (manual mode only)
//  cs_sel       in   SEL_W    target channel for the next auto frame
//  cs_req       in   1        level request from shift FSM, sampled only in IDLE
//  frame_done   in   1        1-cycle pulse from shift FSM: last bit shifted
//  cs_keep      in   1        with frame_done: keep CS asserted for a back-to-back frame
//  lead_cycles  in   DELAY_W  extra cycles from CS assert to cs_ready
//  trail_cycles in   DELAY_W  extra cycles from frame_done to CS deassert
//  gap_cycles   in   DELAY_W  minimum extra idle cycles after deassert
//  cs           out  NUM_CS   chip-select lines (registered)
//  cs_ready     out  1        CS settled; shift FSM may clock SCLK (registered)
//  busy         out  1        auto FSM not in IDLE
//  sel_err      out  1        1-cycle pulse: auto request with cs_sel >= NUM_CS
// BEHAVIOUR
//  - reset, or enable=0: next edge all cs inactive, cs_ready=0, busy=0, sel_err=0, FSM=IDLE, counters=0.
//  - Auto FSM states: IDLE, LEAD, ACTIVE, TRAIL, GAP. busy = (state != IDLE).
//  - IDLE: cs_req=1 and cs_sel<NUM_CS at edge T -> latch sel; at T+1 cs[sel] active, state=LEAD, cnt=lead_cycles.
//    cs_req=1 and cs_sel>=NUM_CS -> sel_err=1 for one cycle; stay IDLE; no CS change.
//  - LEAD: cnt!=0 -> decrement. cnt==0 -> ACTIVE with cs_ready=1 on the same edge.
//    With lead=0, cs_ready rises at T+2; in general at T+2+lead_cycles.
//  - ACTIVE: frame_done & cs_keep -> stay ACTIVE, cs_ready stays 1.
//    frame_done & !cs_keep -> TRAIL, cnt=trail_cycles, cs_ready=0 next edge.
//    cs_req is ignored in ACTIVE.
//  - TRAIL: cnt!=0 -> decrement. cnt==0 -> cs[sel] inactive next edge, state=GAP, cnt=gap_cycles.
//  - GAP: cnt!=0 -> decrement. cnt==0 -> IDLE; a held cs_req is sampled on the next edge.
//  - Auto mode: at most one cs line active; the latched sel holds for the whole frame
//    (cs_sel changes mid-frame are ignored).
//  - Manual mode (cs_auto=0): FSM forced to IDLE. Each edge, cs[i] = active iff cs_manual[i].
//    Multiple lines may be active. cs_ready=1, busy=0, frame_done/cs_req ignored.
//  - Mode switch mid-frame, auto->manual: FSM to IDLE on the next edge, cs follows cs_manual.
//    Manual->auto: all cs inactive on the next edge, then normal IDLE handling.
//  - enable dropping mid-frame: abort, same as reset (no trail/gap timing applied).
//  - Counters saturate at 0 and never wrap; delay inputs are sampled when each counter loads.
// CONFIGURATION
//  - SPI_CS_POLARITY_EN defined: extra input cs_pol [NUM_CS]; active level of cs[i] = cs_pol[i],
//    inactive = ~cs_pol[i]. Reset/disable drive ~cs_pol. cs_pol is applied combinationally
//    on the registered active flags.
//  - Not defined: no cs_pol port; all lines active-low, inactive = 1.
// TESTING
//  1. NUM_CS=4, lead=2, trail=1, gap=3, sel=2, cs_req at T:
//     -> cs=4'b1011 at T+1, cs_ready at T+4; frame_done at T+10 -> cs_ready=0 at T+11,
//        cs=4'b1111 at T+13, busy=0 at T+17.
//  2. Zero delays, cs_req held: -> cs_ready at T+2; after frame_done, next frame's cs reasserts
//     exactly after a single GAP cycle with cnt=0; no glitch on other lines.
//  3. Two frame_done pulses with cs_keep=1, then one with cs_keep=0 -> cs[sel] held active
//     throughout; cs_ready never drops until the last frame.
//  4. cs_sel=5 with NUM_CS=4 (SEL_W=3), cs_req=1 -> sel_err 1-cycle pulse, cs=4'b1111, busy=0.
//  5. Manual mask 4'b0101 -> cs=4'b1010; switch to auto mid-frame -> 4'b1111 next edge;
//     enable=0 during LEAD -> all inactive, cs_ready=0, FSM=IDLE next edge.
//  6. With SPI_CS_POLARITY_EN, cs_pol=4'b0001 -> reset value cs=4'b1110;
//     auto sel=0 asserts cs=4'b1111.

Source files
------------

// File: rtl/spi_cs_ctrl_if.sv
// Bundle of control, timing and status signals between the SPI control logic and spi_cs_ctrl.
// The cs_pol lane exists only when SPI_CS_POLARITY_EN is defined.
interface spi_cs_ctrl_if #(
  parameter int NUM_CS  = 4,
  parameter int SEL_W   = 2,
  parameter int DELAY_W = 4
);
  logic               enable;
  logic               cs_auto;
  logic [NUM_CS-1:0]  cs_manual;
  logic [SEL_W-1:0]   cs_sel;
  logic               cs_req;
  logic               frame_done;
  logic               cs_keep;
  logic [DELAY_W-1:0] lead_cycles;
  logic [DELAY_W-1:0] trail_cycles;
  logic [DELAY_W-1:0] gap_cycles;
`ifdef SPI_CS_POLARITY_EN
  logic [NUM_CS-1:0]  cs_pol;
`endif
  logic [NUM_CS-1:0]  cs;
  logic               cs_ready;
  logic               busy;
  logic               sel_err;

  modport master (
`ifdef SPI_CS_POLARITY_EN
    output cs_pol,
`endif
    output enable, cs_auto, cs_manual, cs_sel, cs_req, frame_done, cs_keep,
    output lead_cycles, trail_cycles, gap_cycles,
    input  cs, cs_ready, busy, sel_err
  );

  modport slave (
`ifdef SPI_CS_POLARITY_EN
    input  cs_pol,
`endif
    input  enable, cs_auto, cs_manual, cs_sel, cs_req, frame_done, cs_keep,
    input  lead_cycles, trail_cycles, gap_cycles,
    output cs, cs_ready, busy, sel_err
  );
endinterface

// File: rtl/spi_cs_ctrl.sv
// Multi-channel SPI chip-select controller: auto (sequenced lead/trail/gap) or manual mask mode.
// Optional SPI_CS_POLARITY_EN adds per-line active polarity via bus.cs_pol; default is active-low.
//
//  state  | meaning
//  IDLE   | no frame; samples cs_req/cs_sel
//  LEAD   | CS asserted, counting lead cycles before cs_ready
//  ACTIVE | cs_ready high, waiting for frame_done
//  TRAIL  | cs_ready low, CS still asserted for trail cycles
//  GAP    | CS released, enforcing minimum idle time
module spi_cs_ctrl #(
  parameter int NUM_CS  = 4,
  parameter int SEL_W   = 2,
  parameter int DELAY_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_cs_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    ACTIVE = 3'd2,
    TRAIL  = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [SEL_W:0] NUM_CS_L = (SEL_W+1)'(NUM_CS);

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [NUM_CS-1:0]  cs_act_q, cs_act_d;
  logic               cs_ready_q, cs_ready_d;
  logic               busy_q, busy_d;
  logic               sel_err_q, sel_err_d;
  logic               manual_q, manual_d;
  logic               sel_ok;
  logic [NUM_CS-1:0]  sel_hot;

  always_comb begin
    sel_ok  = ({1'b0, bus.cs_sel} < NUM_CS_L);
    sel_hot = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      sel_hot[i] = (bus.cs_sel == SEL_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_act_d   = cs_act_q;
    cs_ready_d = cs_ready_q;
    busy_d     = busy_q;
    sel_err_d  = 1'b0;
    manual_d   = manual_q;

    if (!bus.enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      cs_act_d   = '0;
      cs_ready_d = 1'b0;
      busy_d     = 1'b0;
      manual_d   = 1'b0;
    end else if (!bus.cs_auto) begin
      state_d    = IDLE;
      cnt_d      = '0;
      cs_act_d   = bus.cs_manual;
      cs_ready_d = 1'b1;
      busy_d     = 1'b0;
      manual_d   = 1'b1;
    end else if (manual_q) begin
      // First auto cycle after manual mode only releases the lines; requests wait one edge.
      state_d    = IDLE;
      cnt_d      = '0;
      cs_act_d   = '0;
      cs_ready_d = 1'b0;
      busy_d     = 1'b0;
      manual_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cs_act_d   = '0;
          cs_ready_d = 1'b0;
          if (bus.cs_req) begin
            if (sel_ok) begin
              cs_act_d = sel_hot;
              cnt_d    = bus.lead_cycles;
              state_d  = LEAD;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
        LEAD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DELAY_W'(1);
          end else begin
            state_d    = ACTIVE;
            cs_ready_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.frame_done && !bus.cs_keep) begin
            state_d    = TRAIL;
            cnt_d      = bus.trail_cycles;
            cs_ready_d = 1'b0;
          end
        end
        TRAIL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DELAY_W'(1);
          end else begin
            state_d  = GAP;
            cs_act_d = '0;
            cnt_d    = bus.gap_cycles;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DELAY_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          cs_act_d   = '0;
          cs_ready_d = 1'b0;
        end
      endcase
      busy_d = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cs_act_q   <= '0;
      cs_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      sel_err_q  <= 1'b0;
      manual_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_act_q   <= cs_act_d;
      cs_ready_q <= cs_ready_d;
      busy_q     <= busy_d;
      sel_err_q  <= sel_err_d;
      manual_q   <= manual_d;
    end
  end

`ifdef SPI_CS_POLARITY_EN
  assign bus.cs = ~(cs_act_q ^ bus.cs_pol);
`else
  assign bus.cs = ~cs_act_q;
`endif
  assign bus.cs_ready = cs_ready_q;
  assign bus.busy     = busy_q;
  assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Directed bench for spi_cs_ctrl with a queue of expected per-cycle outputs.
// Expected line levels are derived from active masks, honouring SPI_CS_POLARITY_EN when defined.
module tb_spi_cs_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] pol = 4'b0001;

  always #5 clk = ~clk;

  spi_cs_ctrl_if #(.NUM_CS(4), .SEL_W(3), .DELAY_W(4)) ifc();

  spi_cs_ctrl #(.NUM_CS(4), .SEL_W(3), .DELAY_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    string      tag;
    logic [3:0] act;
    logic       rdy;
    logic       bsy;
    logic       err;
  } exp_t;

  exp_t sb[$];

  function automatic logic [3:0] phys(input logic [3:0] act);
`ifdef SPI_CS_POLARITY_EN
    return ~(act ^ pol);
`else
    return ~act;
`endif
  endfunction

  task automatic push(input string tag, input logic [3:0] act, input logic rdy,
                      input logic bsy, input logic err);
    exp_t e;
    e.tag = tag; e.act = act; e.rdy = rdy; e.bsy = bsy; e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop();
    exp_t e;
    logic [6:0] obs_v, exp_v;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: observed no expectation, expected one queued");
      return;
    end
    e = sb.pop_front();
    obs_v = {ifc.cs, ifc.cs_ready, ifc.busy, ifc.sel_err};
    exp_v = {phys(e.act), e.rdy, e.bsy, e.err};
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s: observed cs=%b rdy=%b busy=%b err=%b expected cs=%b rdy=%b busy=%b err=%b",
             e.tag, obs_v[6:3], obs_v[2], obs_v[1], obs_v[0],
             exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // One auto frame: request sampled at edge 1, frame_done (final) at edge rdy_on+flen.
  task automatic run_frame(input string tag, input int lead, input int trail, input int gap,
                           input logic [2:0] sel, input int flen, input int nkeep,
                           input logic hold);
    int rdy_on, f, off, idle;
    logic [3:0] m;
    m      = 4'b0001 << sel;
    rdy_on = lead + 2;
    f      = rdy_on + flen;
    off    = f + trail + 1;
    idle   = off + gap + 1;
    for (int n = 1; n <= idle; n++) begin
      push(tag, (n < off) ? m : 4'b0000, (n >= rdy_on) && (n < f), n < idle, 1'b0);
    end
    ifc.lead_cycles  = lead[3:0];
    ifc.trail_cycles = trail[3:0];
    ifc.gap_cycles   = gap[3:0];
    ifc.cs_sel       = sel;
    ifc.cs_req       = 1'b1;
    for (int n = 1; n <= idle; n++) begin
      ifc.frame_done = (n == f) ||
                       ((n > rdy_on) && (n < f) && ((n - rdy_on) % 2 == 0) &&
                        ((n - rdy_on) / 2 <= nkeep));
      ifc.cs_keep    = (n != f);
      tick();
      ifc.cs_req     = hold;
      ifc.frame_done = 1'b0;
      ifc.cs_keep    = 1'b0;
      if (n == 1) begin
        ifc.cs_sel      = sel ^ 3'd1;
        ifc.lead_cycles = 4'd9;
      end
      check_pop();
    end
  endtask

  initial begin
    reset            = 1'b1;
    ifc.enable       = 1'b0;
    ifc.cs_auto      = 1'b0;
    ifc.cs_manual    = 4'b0000;
    ifc.cs_sel       = 3'd0;
    ifc.cs_req       = 1'b0;
    ifc.frame_done   = 1'b0;
    ifc.cs_keep      = 1'b0;
    ifc.lead_cycles  = 4'd0;
    ifc.trail_cycles = 4'd0;
    ifc.gap_cycles   = 4'd0;
`ifdef SPI_CS_POLARITY_EN
    ifc.cs_pol       = pol;
`endif
    tick();
    push("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_pop();

    reset = 1'b0; ifc.enable = 1'b1; ifc.cs_auto = 1'b1;
    push("idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    run_frame("t1_timing", 2, 1, 3, 3'd2, 7, 0, 1'b0);
    run_frame("t2_zero_a", 0, 0, 0, 3'd1, 3, 0, 1'b1);
    run_frame("t2_zero_b", 0, 0, 0, 3'd1, 3, 0, 1'b0);
    run_frame("t3_keep",   1, 2, 1, 3'd3, 7, 2, 1'b0);

    ifc.cs_sel = 3'd5; ifc.cs_req = 1'b1;
    push("t4_selerr5", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick(); check_pop();
    ifc.cs_req = 1'b0;
    push("t4_clear5", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.cs_sel = 3'd4; ifc.cs_req = 1'b1;
    push("t4_selerr4", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick(); check_pop();
    ifc.cs_req = 1'b0;
    push("t4_clear4", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    ifc.cs_auto = 1'b0; ifc.cs_manual = 4'b0101;
    push("t5_manual", 4'b0101, 1'b1, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.cs_manual = 4'b1100; ifc.cs_req = 1'b1; ifc.frame_done = 1'b1;
    push("t5_manual2", 4'b1100, 1'b1, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.frame_done = 1'b0;
    ifc.cs_auto = 1'b1; ifc.cs_sel = 3'd1; ifc.lead_cycles = 4'd3;
    push("t5_to_auto", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();
    push("t5_req_after", 4'b0010, 1'b0, 1'b1, 1'b0);
    tick(); check_pop();
    ifc.cs_req = 1'b0;
    push("t5_lead", 4'b0010, 1'b0, 1'b1, 1'b0);
    tick(); check_pop();
    ifc.enable = 1'b0;
    push("t5_disable", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.enable = 1'b1;
    push("t5_reenable", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    ifc.lead_cycles = 4'd0; ifc.cs_sel = 3'd0; ifc.cs_req = 1'b1;
    push("t5b_lead", 4'b0001, 1'b0, 1'b1, 1'b0);
    tick(); check_pop();
    ifc.cs_req = 1'b0;
    push("t5b_active", 4'b0001, 1'b1, 1'b1, 1'b0);
    tick(); check_pop();
    ifc.cs_auto = 1'b0; ifc.cs_manual = 4'b1000;
    push("t5b_to_manual", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.cs_auto = 1'b1; ifc.cs_manual = 4'b0000;
    push("t5b_back_auto", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    ifc.cs_auto = 1'b0; ifc.cs_manual = 4'b1111; ifc.enable = 1'b0;
    push("t5_dis_manual", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.enable = 1'b1;
    push("t5_en_manual", 4'b1111, 1'b1, 1'b0, 1'b0);
    tick(); check_pop();
    ifc.cs_auto = 1'b1; ifc.cs_manual = 4'b0000;
    push("t5_release", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    ifc.cs_sel = 3'd3; ifc.lead_cycles = 4'd5; ifc.cs_req = 1'b1;
    push("rst_lead", 4'b1000, 1'b0, 1'b1, 1'b0);
    tick(); check_pop();
    ifc.cs_req = 1'b0; reset = 1'b1;
    push("rst_midframe", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();
    reset = 1'b0;
    push("rst_after", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); check_pop();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
